// File: rtl/ysyx_24120013_fetch.sv
// ysyx_24120013_fetch: instruction fetch stage with single-outstanding memory requests and a small output queue
module ysyx_24120013_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000,
  parameter int QDEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  input  logic                  mem_resp_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic                  out_fault
);
  localparam int PW = $clog2(QDEPTH);
  typedef enum logic [1:0] {REQ, WAIT, DROP, HALT} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] fetch_pc, req_pc;
  logic [PW:0] wr_ptr, rd_ptr, count;
  logic [ADDR_WIDTH-1:0] q_pc [QDEPTH];
  logic [DATA_WIDTH-1:0] q_inst [QDEPTH];
  logic [QDEPTH-1:0] q_fault;
  logic full, hs, push, pop;
  assign count = wr_ptr - rd_ptr;
  assign full = count[PW];
  assign mem_req_valid = !rst && state == REQ && !full;
  assign mem_req_addr = fetch_pc;
  assign hs = mem_req_valid && mem_req_ready;
  assign push = state == WAIT && mem_resp_valid;
  assign out_valid = |count;
  assign pop = out_valid && out_ready;
  assign out_pc = q_pc[rd_ptr[PW-1:0]];
  assign out_inst = q_inst[rd_ptr[PW-1:0]];
  assign out_fault = q_fault[rd_ptr[PW-1:0]];
  always_comb begin
    state_nx = state;
    case (state)
      REQ:     state_nx = hs ? (redirect_valid ? DROP : WAIT) : REQ;
      WAIT:    state_nx = mem_resp_valid ? ((mem_resp_err && !redirect_valid) ? HALT : REQ)
                                         : (redirect_valid ? DROP : WAIT);
      DROP:    state_nx = mem_resp_valid ? REQ : DROP;
      HALT:    state_nx = redirect_valid ? REQ : HALT;
      default: state_nx = REQ;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= REQ;
      fetch_pc <= RESET_PC;
      req_pc <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_fault <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc[i] <= '0;
        q_inst[i] <= '0;
      end
    end else begin
      state <= state_nx;
      if (redirect_valid) fetch_pc <= redirect_pc & ~ADDR_WIDTH'(3);
      else if (hs) fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
      if (hs) req_pc <= fetch_pc;
      // a redirect flushes the queue and discards any coincident push or pop
      if (redirect_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          q_pc[wr_ptr[PW-1:0]] <= req_pc;
          q_inst[wr_ptr[PW-1:0]] <= mem_resp_data;
          q_fault[wr_ptr[PW-1:0]] <= mem_resp_err;
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !redirect_valid && full && !pop));
endmodule

// File: tb/tb_ysyx_24120013_fetch.sv
// tb_ysyx_24120013_fetch: directed checks of the fetch stage with a hand-driven memory
module tb_ysyx_24120013_fetch;
  logic clk = 0, rst = 1;
  logic redirect_valid = 0, mem_req_ready = 1, mem_resp_valid = 0, mem_resp_err = 0, out_ready = 0;
  logic [31:0] redirect_pc = 0, mem_resp_data = 0;
  logic mem_req_valid, out_valid, out_fault;
  logic [31:0] mem_req_addr, out_pc, out_inst;
  int n_assert = 0, n_fail = 0;

  ysyx_24120013_fetch dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  task cyc;
    @(posedge clk);
    #1;
  endtask

  task apply_reset;
    rst = 1; redirect_valid = 0; mem_resp_valid = 0; mem_resp_err = 0; mem_req_ready = 1; out_ready = 0;
    cyc; cyc;
    rst = 0;
    #1;
  endtask

  task resp(input logic [31:0] d, input logic e);
    mem_resp_valid = 1; mem_resp_data = d; mem_resp_err = e;
    cyc;
    mem_resp_valid = 0; mem_resp_err = 0;
  endtask

  task test_reset;
    rst = 1;
    cyc;
    n_assert++; if (mem_req_valid !== 0) begin n_fail++; $display("FAIL rst_req_valid got %b exp 0", mem_req_valid); end
    n_assert++; if (mem_req_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL rst_req_addr got %h exp 80000000", mem_req_addr); end
    n_assert++; if (out_valid !== 0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_assert++; if ({out_pc, out_inst, out_fault} !== 65'd0) begin n_fail++; $display("FAIL rst_out_data got %h %h %b exp 0", out_pc, out_inst, out_fault); end
    rst = 0;
    #1;
    n_assert++; if (mem_req_valid !== 1) begin n_fail++; $display("FAIL rel_req_valid got %b exp 1", mem_req_valid); end
  endtask

  task test_fetch;
    logic [31:0] e;
    apply_reset;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      e = 32'h8000_0000 + 32'(4 * i);
      n_assert++; if (mem_req_valid !== 1 || mem_req_addr !== e) begin n_fail++; $display("FAIL fetch_req%0d got %b %h exp 1 %h", i, mem_req_valid, mem_req_addr, e); end
      cyc;
      n_assert++; if (mem_req_valid !== 0) begin n_fail++; $display("FAIL fetch_wait%0d got %b exp 0", i, mem_req_valid); end
      resp(32'h0000_0013, 0);
      n_assert++; if (out_valid !== 1 || out_pc !== e || out_inst !== 32'h13 || out_fault !== 0) begin n_fail++; $display("FAIL fetch_out%0d got %b %h %h %b exp 1 %h 00000013 0", i, out_valid, out_pc, out_inst, out_fault, e); end
    end
    cyc;
    n_assert++; if (out_valid !== 0) begin n_fail++; $display("FAIL fetch_drain got %b exp 0", out_valid); end
  endtask

  task test_backpressure;
    apply_reset;
    cyc; resp(32'h13, 0);
    cyc; resp(32'h13, 0);
    cyc; cyc;
    n_assert++; if (mem_req_valid !== 0) begin n_fail++; $display("FAIL bp_full_req got %b exp 0", mem_req_valid); end
    n_assert++; if (out_valid !== 1 || out_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL bp_head got %b %h exp 1 80000000", out_valid, out_pc); end
    out_ready = 1;
    cyc;
    out_ready = 0;
    n_assert++; if (out_pc !== 32'h8000_0004) begin n_fail++; $display("FAIL bp_pop got %h exp 80000004", out_pc); end
    n_assert++; if (mem_req_valid !== 1 || mem_req_addr !== 32'h8000_0008) begin n_fail++; $display("FAIL bp_req got %b %h exp 1 80000008", mem_req_valid, mem_req_addr); end
    cyc; resp(32'h13, 0);
    cyc;
    n_assert++; if (mem_req_valid !== 0 || out_valid !== 1) begin n_fail++; $display("FAIL bp_one_req got %b %b exp 0 1", mem_req_valid, out_valid); end
  endtask

  task test_redirect_wait;
    apply_reset;
    cyc;
    redirect_valid = 1; redirect_pc = 32'h8000_1003;
    cyc;
    redirect_valid = 0;
    n_assert++; if (out_valid !== 0 || mem_req_valid !== 0) begin n_fail++; $display("FAIL rw_drop got %b %b exp 0 0", out_valid, mem_req_valid); end
    resp(32'hdead_beef, 0);
    n_assert++; if (out_valid !== 0) begin n_fail++; $display("FAIL rw_discard got %b exp 0", out_valid); end
    n_assert++; if (mem_req_valid !== 1 || mem_req_addr !== 32'h8000_1000) begin n_fail++; $display("FAIL rw_req got %b %h exp 1 80001000", mem_req_valid, mem_req_addr); end
    cyc; resp(32'h13, 0);
    n_assert++; if (out_valid !== 1 || out_pc !== 32'h8000_1000 || out_inst !== 32'h13) begin n_fail++; $display("FAIL rw_out got %b %h %h exp 1 80001000 00000013", out_valid, out_pc, out_inst); end
  endtask

  task test_redirect_hs_resp;
    apply_reset;
    redirect_valid = 1; redirect_pc = 32'h8000_2000;
    cyc;
    redirect_valid = 0;
    n_assert++; if (mem_req_valid !== 0) begin n_fail++; $display("FAIL rh_drop got %b exp 0", mem_req_valid); end
    resp(32'hdead_beef, 0);
    n_assert++; if (out_valid !== 0 || mem_req_valid !== 1 || mem_req_addr !== 32'h8000_2000) begin n_fail++; $display("FAIL rh_after got %b %b %h exp 0 1 80002000", out_valid, mem_req_valid, mem_req_addr); end
    cyc;
    redirect_valid = 1; redirect_pc = 32'h8000_3000;
    resp(32'hbad0_bad0, 0);
    redirect_valid = 0;
    n_assert++; if (out_valid !== 0 || mem_req_valid !== 1 || mem_req_addr !== 32'h8000_3000) begin n_fail++; $display("FAIL rr_after got %b %b %h exp 0 1 80003000", out_valid, mem_req_valid, mem_req_addr); end
    cyc; resp(32'h13, 0);
    n_assert++; if (out_valid !== 1 || out_pc !== 32'h8000_3000 || out_inst !== 32'h13) begin n_fail++; $display("FAIL rr_out got %b %h %h exp 1 80003000 00000013", out_valid, out_pc, out_inst); end
  endtask

  task test_fault;
    apply_reset;
    out_ready = 1;
    cyc; resp(32'h13, 0);
    cyc; resp(32'h13, 0);
    cyc; resp(32'h0000_0073, 1);
    n_assert++; if (out_valid !== 1 || out_pc !== 32'h8000_0008 || out_fault !== 1) begin n_fail++; $display("FAIL flt_out got %b %h %b exp 1 80000008 1", out_valid, out_pc, out_fault); end
    n_assert++; if (mem_req_valid !== 0) begin n_fail++; $display("FAIL flt_halt got %b exp 0", mem_req_valid); end
    cyc; cyc; cyc;
    n_assert++; if (mem_req_valid !== 0 || out_valid !== 0) begin n_fail++; $display("FAIL flt_stay got %b %b exp 0 0", mem_req_valid, out_valid); end
    redirect_valid = 1; redirect_pc = 32'h8000_0100;
    cyc;
    redirect_valid = 0;
    n_assert++; if (mem_req_valid !== 1 || mem_req_addr !== 32'h8000_0100) begin n_fail++; $display("FAIL flt_resume got %b %h exp 1 80000100", mem_req_valid, mem_req_addr); end
    out_ready = 0;
    cyc; resp(32'h13, 0);
    n_assert++; if (out_valid !== 1 || out_pc !== 32'h8000_0100 || out_fault !== 0) begin n_fail++; $display("FAIL flt_next got %b %h %b exp 1 80000100 0", out_valid, out_pc, out_fault); end
  endtask

  task test_wrap;
    apply_reset;
    mem_req_ready = 0;
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFF;
    cyc;
    redirect_valid = 0; mem_req_ready = 1;
    n_assert++; if (mem_req_valid !== 1 || mem_req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req got %b %h exp 1 fffffffc", mem_req_valid, mem_req_addr); end
    cyc; resp(32'h13, 0);
    n_assert++; if (out_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_out got %h exp fffffffc", out_pc); end
    n_assert++; if (mem_req_valid !== 1 || mem_req_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next got %b %h exp 1 00000000", mem_req_valid, mem_req_addr); end
  endtask

  task test_async_reset;
    apply_reset;
    cyc; resp(32'h13, 0);
    cyc;
    n_assert++; if (out_valid !== 1) begin n_fail++; $display("FAIL ar_pre got %b exp 1", out_valid); end
    #2 rst = 1;
    #1;
    n_assert++; if (out_valid !== 0 || mem_req_valid !== 0 || mem_req_addr !== 32'h8000_0000 || out_pc !== 0) begin n_fail++; $display("FAIL ar_async got %b %b %h %h exp 0 0 80000000 0", out_valid, mem_req_valid, mem_req_addr, out_pc); end
    cyc;
    rst = 0;
    #1;
    n_assert++; if (mem_req_valid !== 1 || out_valid !== 0) begin n_fail++; $display("FAIL ar_release got %b %b exp 1 0", mem_req_valid, out_valid); end
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_backpressure;
    test_redirect_wait;
    test_redirect_hs_resp;
    test_fault;
    test_wrap;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_24120013_fetch.md
Name: ysyx_24120013_fetch

Overview:
Instruction fetch stage that sits upstream of the decode stage. It owns the fetch PC, issues single-outstanding requests to instruction memory over a valid/ready request channel and a valid-only response channel, and buffers fetched words in a 2-entry queue. The queue presents {pc, inst, fault} to the decoder with a valid/ready handshake. A redirect input from execute flushes wrong-path work.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address
DATA_WIDTH, 32, instruction word width
RESET_PC, 32'h8000_0000, first fetch address after reset
QDEPTH, 2, output queue entries (power of two, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset; asynchronous, active-high
redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
redirect_pc  in  ADDR_WIDTH  new fetch address; bits [1:0] ignored and treated as 0
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_WIDTH  request address (word aligned)
mem_resp_valid  in  1  response valid, one cycle per accepted request
mem_resp_data  in  DATA_WIDTH  instruction word
mem_resp_err  in  1  access fault for this response
out_valid  out  1  queue head valid
out_ready  in  1  decoder consumes head
out_pc  out  ADDR_WIDTH  PC of head entry
out_inst  out  DATA_WIDTH  instruction of head entry
out_fault  out  1  head entry carries an access fault

Behaviour:
- Reset (async, while rst=1): state=REQ, fetch_pc=RESET_PC, queue empty with both pointers 0, storage cleared. out_valid=0, out_pc=0, out_inst=0, out_fault=0, mem_req_valid=0, mem_req_addr=RESET_PC.
- Reset mid-transaction: all in-flight work is forgotten. The memory side must not return a response after rst deasserts for a pre-reset request.
- FSM states: REQ, WAIT, DROP, HALT.
- REQ:
  - mem_req_valid = (count < QDEPTH); mem_req_addr = fetch_pc.
  - On handshake (valid & ready): fetch_pc += 4 (modulo 2^ADDR_WIDTH, wraps at all-ones), go to WAIT.
  - Once asserted, valid and addr hold until accepted. The only exception is a redirect, which may change addr or drop valid.
- WAIT: mem_req_valid=0. On mem_resp_valid, push {req_pc, data, err}; req_pc is a register captured at the handshake. Then go to HALT if err=1, else REQ.
- DROP: mem_req_valid=0. The next mem_resp_valid is discarded with no push; go to REQ.
- HALT: no requests. Only a redirect leaves HALT.
- Slot reservation: a request is issued only if count < QDEPTH at issue time. No pop occurs between issue and push except via out_ready, so a push never finds the queue full. An overflow is an assertion failure.
- Redirect (highest priority, same edge):
  - fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}; queue flushed (count=0, pointers=0).
  - State transitions on redirect:
    - from REQ with no handshake this cycle: go to REQ.
    - from REQ with a handshake this cycle: go to DROP (the accepted request is wrong-path).
    - from WAIT with no response this cycle: go to DROP.
    - from WAIT with a response this cycle: go to REQ; the response is discarded.
    - from DROP without a response: stay in DROP.
    - from DROP with a response: go to REQ.
    - from HALT: go to REQ.
  - A pop coinciding with a redirect is ignored; the flush wins.
- Queue:
  - Circular buffer; wrap pointers carry an extra bit so full and empty are distinguishable.
  - out_valid = count != 0; outputs are driven from the head entry, combinationally from storage.
  - Pop on out_valid & out_ready. Simultaneous push and pop: count unchanged, both pointers advance.
  - When empty, out_pc, out_inst and out_fault hold their last values and are don't-care; the bench must not check them.
- Latency:
  - Request accepted at edge N with a response in cycle M: the entry is visible on out_* in cycle M+1.
  - Next request earliest in cycle M+1.
  - With a zero-wait memory, throughput is 1 instruction per 2 cycles.

Test Plan:
- Reset release, memory always ready, 1-cycle response with data 0x00000013 for each address -> requests to 0x80000000, 0x80000004, 0x80000008; out_pc sequence matches, out_inst=0x00000013, out_fault=0.
- out_ready held 0 -> after 2 entries mem_req_valid stays 0. Then one out_ready pulse -> pop 0x80000000, exactly one new request issued.
- Redirect to 0x80001003 while in WAIT -> next response discarded, queue empty, next request address 0x80001000, following out_pc 0x80001000.
- Redirect in the same cycle as a request handshake -> next response dropped, no stale entry reaches out_*. Redirect in the same cycle as a response -> that response is dropped.
- mem_resp_err=1 on address 0x80000008 -> entry presented with out_fault=1, no further requests. Redirect to 0x80000100 -> fetch resumes there.
- fetch_pc=32'hFFFFFFFC after redirect -> next request at 0x00000000 (wrap). Assert rst while in WAIT -> out_valid=0 and mem_req_addr=0x80000000 immediately, without waiting for a clock edge.
